// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: funct codes, ALU op encodings and multiply/divide engine states
package alu_ctl_pkg;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLTU = 6'h2B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [6:0] OP_ADD = 7'b0101000, OP_SUB = 7'b1010100, OP_AND = 7'b0001001;
  localparam logic [6:0] OP_OR = 7'b0111001, OP_XOR = 7'b0110001, OP_NOR = 7'b1000001;
  localparam logic [6:0] OP_SLTU = 7'b1010111, OP_NONE = 7'b0000000;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
endpackage

// File: rtl/md_datapath.sv
// md_datapath: magnitude shift-add multiply / restoring divide with final sign fixup
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH-1:0] m_q, m_d, ph_q, ph_d, pl_q, pl_d;
  logic div_q, div_d, na_q, na_d, nb_q, nb_d, neg;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, m_q} : '0);
    sh = {ph_q, pl_q[WIDTH-1]};
    diff = sh - {1'b0, m_q};
    m_d = m_q;
    ph_d = ph_q;
    pl_d = pl_q;
    div_d = div_q;
    na_d = na_q;
    nb_d = nb_q;
    if (load_i) begin
      na_d = sgn_i && a_i[WIDTH-1];
      nb_d = sgn_i && b_i[WIDTH-1];
      m_d = nb_d ? -b_i : b_i;
      pl_d = na_d ? -a_i : a_i;
      ph_d = '0;
      div_d = div_i;
    end else if (step_i) begin
      ph_d = div_q ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      pl_d = div_q ? {pl_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], pl_q[WIDTH-1:1]};
    end
    neg = na_q ^ nb_q;
    prod = neg ? -{ph_q, pl_q} : {ph_q, pl_q};
    // divide by zero yields all-ones quotient; remainder keeps dividend sign so it equals a
    hi_o = div_q ? (na_q ? -ph_q : ph_q) : prod[2*WIDTH-1:WIDTH];
    lo_o = div_q ? (m_q == '0 ? '1 : (neg ? -pl_q : pl_q)) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    m_q <= m_d;
    ph_q <= ph_d;
    pl_q <= pl_d;
    div_q <= div_d;
    na_q <= na_d;
    nb_q <= nb_d;
  end
endmodule

// File: rtl/alu_ctl_md.sv
// alu_ctl_md: ALU op decode plus a multi-cycle HI/LO multiply/divide engine with stall
module alu_ctl_md
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [6:0]       op,
  output logic             stall,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic done_q, is_r, is_div, is_mv, go;
  always_comb begin
    is_r = alu_op == 2'b10;
    is_div = DIV_EN && is_r && (funct == F_DIV || funct == F_DIVU);
    is_mv = is_r && funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    go = valid && state_q == IDLE && (is_div || (is_r && (funct == F_MULT || funct == F_MULTU)));
    op = alu_op == 2'b00 ? OP_ADD : alu_op == 2'b01 ? OP_SUB : !is_r ? OP_NONE :
         funct == F_ADD ? OP_ADD : funct == F_SUB ? OP_SUB : funct == F_AND ? OP_AND :
         funct == F_OR ? OP_OR : funct == F_XOR ? OP_XOR : funct == F_NOR ? OP_NOR :
         funct == F_SLTU ? OP_SLTU : OP_NONE;
    // HI/LO moves wait out the engine, including its DONE cycle
    stall = state_q == RUN || state_q == FIX || go || (valid && is_mv && state_q != IDLE);
    md_sel = valid && is_r && (funct == F_MFHI || funct == F_MFLO);
    md_result = is_r && funct == F_MFHI ? hi_q : lo_q;
    md_done = done_q;
    hi = hi_q;
    lo = lo_q;
  end
  md_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .load_i (go),
    .step_i (state_q == RUN),
    .div_i  (is_div),
    .sgn_i  (funct == F_MULT || funct == F_DIV),
    .a_i    (a),
    .b_i    (b),
    .hi_o   (res_hi),
    .lo_o   (res_lo)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == FIX;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (go) state_q <= RUN;
          if (valid && is_r && funct == F_MTHI) hi_q <= a;
          if (valid && is_r && funct == F_MTLO) lo_q <= a;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctl_md.sv
// tb_alu_ctl_md: directed vectors for decode, mult/div results, latency, stalls and reset abort
module tb_alu_ctl_md;
  logic clk = 1'b0, reset, valid, stall, md_sel, md_done;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [31:0] a, b, md_result, hi, lo;
  logic [6:0] op;
  int checks = 0, failures = 0;
  typedef struct {logic [1:0] ao; logic [5:0] f; logic [6:0] exp;} dvec_t;

  always #5 clk = ~clk;

  alu_ctl_md #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .op(op), .stall(stall), .md_sel(md_sel), .md_result(md_result), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents an MD instruction and holds it until md_done, leaving the bench in the DONE cycle.
  task automatic issue_md(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output int nstall, output int done_at);
    nstall = 0;
    done_at = 0;
    valid = 1'b1;
    alu_op = 2'b10;
    funct = f;
    a = av;
    b = bv;
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      #2;
      if (stall) nstall++;
      if (md_done) done_at = c;
      else tick();
    end
  endtask

  task automatic retire;
    tick();
    valid = 1'b0;
    alu_op = 2'b11;
    funct = 6'h00;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    valid = 1'b0;
    alu_op = 2'b11;
    funct = 6'h00;
    a = 0;
    b = 0;
    repeat (2) tick();
    reset = 1'b0;
    alu_op = 2'b10;
    funct = 6'h20;
    #1;
    checks++; if (op !== 7'b0101000) begin failures++; $display("FAIL rst_op got=%b exp=0101000", op); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL rst_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", md_done); end
    alu_op = 2'b11;
    #1;
    checks++; if (op !== 7'b0000000) begin failures++; $display("FAIL rst_none got=%b exp=0000000", op); end
    tick();
  endtask

  task automatic test_decode;
    dvec_t v [14];
    v = '{'{2'b00, 6'h00, 7'b0101000}, '{2'b01, 6'h00, 7'b1010100}, '{2'b11, 6'h20, 7'b0000000},
          '{2'b10, 6'h20, 7'b0101000}, '{2'b10, 6'h22, 7'b1010100}, '{2'b10, 6'h24, 7'b0001001},
          '{2'b10, 6'h25, 7'b0111001}, '{2'b10, 6'h26, 7'b0110001}, '{2'b10, 6'h27, 7'b1000001},
          '{2'b10, 6'h2B, 7'b1010111}, '{2'b10, 6'h18, 7'b0000000}, '{2'b10, 6'h10, 7'b0000000},
          '{2'b10, 6'h2A, 7'b0000000}, '{2'b00, 6'h22, 7'b0101000}};
    valid = 1'b0;
    foreach (v[i]) begin
      alu_op = v[i].ao;
      funct = v[i].f;
      #1;
      checks++; if (op !== v[i].exp) begin failures++; $display("FAIL dec_%0d ao=%b f=%h got=%b exp=%b", i, v[i].ao, v[i].f, op, v[i].exp); end
    end
    alu_op = 2'b10;
    funct = 6'h10;
    #1;
    checks++; if (md_sel !== 1'b0) begin failures++; $display("FAIL sel_novalid got=%b exp=0", md_sel); end
    valid = 1'b1;
    #1;
    checks++; if (md_sel !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL sel_mfhi sel/stall got=%b/%b exp=1/0", md_sel, stall); end
    alu_op = 2'b00;
    #1;
    checks++; if (md_sel !== 1'b0) begin failures++; $display("FAIL sel_notr got=%b exp=0", md_sel); end
    funct = 6'h18;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_notr_stall got=%b exp=0", stall); end
    valid = 1'b0;
    tick();
    checks++; if (stall !== 1'b0 || md_done !== 1'b0) begin failures++; $display("FAIL notr_idle stall/done got=%b/%b exp=0/0", stall, md_done); end
  endtask

  task automatic test_multu;
    int ns, da;
    issue_md(6'h19, 32'hFFFF_FFFF, 32'h2, ns, da);
    checks++; if (ns !== 34) begin failures++; $display("FAIL multu_stall got=%0d exp=34", ns); end
    checks++; if (da !== 35) begin failures++; $display("FAIL multu_done_cycle got=%0d exp=35", da); end
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_res got=%h_%h exp=00000001_fffffffe", hi, lo); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL multu_done_stall got=%b exp=0", stall); end
    retire();
    checks++; if (md_done !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL multu_pulse done/stall got=%b/%b exp=0/0", md_done, stall); end
  endtask

  task automatic test_signed;
    int ns, da;
    issue_md(6'h18, 32'hFFFF_FFFD, 32'h5, ns, da);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || da !== 35) begin failures++; $display("FAIL mult_neg got=%h_%h at %0d exp=ffffffff_fffffff1 at 35", hi, lo, da); end
    retire();
    issue_md(6'h1A, 32'hFFFF_FFF9, 32'h2, ns, da);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || ns !== 34) begin failures++; $display("FAIL div_neg got lo=%h hi=%h stall=%0d exp lo=fffffffd hi=ffffffff stall=34", lo, hi, ns); end
    retire();
    issue_md(6'h1B, 32'd100, 32'd7, ns, da);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL divu_plain got lo=%h hi=%h exp lo=0000000e hi=00000002", lo, hi); end
    retire();
  endtask

  task automatic test_div_corners;
    int ns, da;
    issue_md(6'h1B, 32'h7, 32'h0, ns, da);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h7) begin failures++; $display("FAIL divu_zero got lo=%h hi=%h exp lo=ffffffff hi=00000007", lo, hi); end
    checks++; if (ns !== 34 || da !== 35) begin failures++; $display("FAIL divu_zero_lat stall=%0d done=%0d exp 34/35", ns, da); end
    retire();
    issue_md(6'h1A, 32'hFFFF_FFF0, 32'h0, ns, da);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF0) begin failures++; $display("FAIL div_zero_neg got lo=%h hi=%h exp lo=ffffffff hi=fffffff0", lo, hi); end
    retire();
    issue_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, ns, da);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin failures++; $display("FAIL div_min got lo=%h hi=%h exp lo=80000000 hi=00000000", lo, hi); end
    checks++; if (ns !== 34 || da !== 35) begin failures++; $display("FAIL div_min_lat stall=%0d done=%0d exp 34/35", ns, da); end
    retire();
  endtask

  task automatic test_mflo_wait;
    int ns = 0, da = 0;
    valid = 1'b1;
    alu_op = 2'b10;
    funct = 6'h18;
    a = 32'd6;
    b = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      #2;
      if (stall) ns++;
      tick();
    end
    funct = 6'h12;
    for (int c = 6; c <= 60 && da == 0; c++) begin
      #2;
      if (stall) ns++;
      if (md_done) da = c;
      else tick();
    end
    checks++; if (da !== 35 || ns !== 35) begin failures++; $display("FAIL mflo_hold done=%0d stall=%0d exp 35/35", da, ns); end
    tick();
    checks++; if (stall !== 1'b0 || md_sel !== 1'b1) begin failures++; $display("FAIL mflo_exec stall/sel got=%b/%b exp=0/1", stall, md_sel); end
    checks++; if (md_result !== 32'h2A) begin failures++; $display("FAIL mflo_result got=%h exp=0000002a", md_result); end
    retire();
  endtask

  task automatic test_mthi;
    valid = 1'b1;
    alu_op = 2'b10;
    funct = 6'h11;
    a = 32'h1234_5678;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall); end
    tick();
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    funct = 6'h13;
    a = 32'h9ABC_DEF0;
    tick();
    checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo got=%h_%h exp=12345678_9abcdef0", hi, lo); end
    funct = 6'h10;
    #1;
    checks++; if (md_sel !== 1'b1 || md_result !== 32'h1234_5678) begin failures++; $display("FAIL mfhi sel=%b res=%h exp 1/12345678", md_sel, md_result); end
    retire();
  endtask

  task automatic test_reset_mid;
    int pulses = 0, ns, da;
    valid = 1'b1;
    alu_op = 2'b10;
    funct = 6'h18;
    a = 32'd100;
    b = 32'd200;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b exp=0", stall); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo); end
    for (int c = 0; c < 40; c++) begin
      if (md_done) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_done pulses=%0d exp=0", pulses); end
    issue_md(6'h19, 32'd3, 32'd4, ns, da);
    checks++; if (lo !== 32'hC || hi !== 32'h0 || da !== 35) begin failures++; $display("FAIL after_abort got=%h_%h at %0d exp=0_0000000c at 35", hi, lo, da); end
    retire();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_multu();
    test_signed();
    test_div_corners();
    test_mflo_wait();
    test_mthi();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
